// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / control-flow controller.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int          REG_ADDR_W_DEF = 5;
  localparam int unsigned REG_ADDR_ZERO  = 0;
  localparam int          PERF_W         = 32;

  // Width of the stall down-counter for a given stall length.
  function automatic int cnt_width(input int load_stall);
    return $clog2(load_stall + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard bundle between the pipeline (master) and the hazard controller (slave).
// All signals are plain levels sampled every cycle; there is no valid/ready handshake.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic                  rs1_use_i;
  logic                  rs2_use_i;
  logic [REG_ADDR_W-1:0] rrd_i;
  logic                  mem_rd_i;
  logic                  branch_taken_i;

  logic                  mux_o;
  logic                  IFID_write_o;
  logic                  pc_write_o;
  logic                  IFID_flush_o;
  logic [PERF_W-1:0]     perf_stall_o;
  logic [PERF_W-1:0]     perf_flush_o;
  state_t                state_dbg_o;

  modport slave (
    input  rs1_i, rs2_i, rs1_use_i, rs2_use_i, rrd_i, mem_rd_i, branch_taken_i,
    output mux_o, IFID_write_o, pc_write_o, IFID_flush_o,
    output perf_stall_o, perf_flush_o, state_dbg_o
  );

  modport master (
    output rs1_i, rs2_i, rs1_use_i, rs2_use_i, rrd_i, mem_rd_i, branch_taken_i,
    input  mux_o, IFID_write_o, pc_write_o, IFID_flush_o,
    input  perf_stall_o, perf_flush_o, state_dbg_o
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// 32-bit saturating event counter with enable and synchronous active-low clear.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_q;
  logic [PERF_W-1:0] cnt_d;

  // Sticks at all-ones instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard and branch-flush controller for the 5-stage pipeline.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LOAD_STALL = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  hazard_ctrl_if.slave  hz
);

  localparam int CNT_W = cnt_width(LOAD_STALL);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic rs1_hit;
  logic rs2_hit;
  logic hit;
  logic stall;
  logic flush;

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign rs1_hit = hz.rs1_use_i && (hz.rs1_i == hz.rrd_i);
  assign rs2_hit = hz.rs2_use_i && (hz.rs2_i == hz.rrd_i);
  assign hit     = hz.mem_rd_i
                && (hz.rrd_i != REG_ADDR_W'(REG_ADDR_ZERO))
                && (rs1_hit || rs2_hit);

  // Gating with rst_n_i releases a stall in the same cycle reset is applied.
  assign stall = rst_n_i && (((state_q == IDLE) && hit) || (state_q == HOLD));
  assign flush = rst_n_i && hz.branch_taken_i && !stall;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && (LOAD_STALL > 1)) begin
            state_q <= HOLD;
            cnt_q   <= CNT_W'(LOAD_STALL - 1);
          end
        end
        HOLD: begin
          // EX carries the bubble we inserted, so its inputs are not looked at here.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign hz.mux_o        = stall;
  assign hz.IFID_write_o = !stall;
  assign hz.pc_write_o   = !stall;
  assign hz.IFID_flush_o = flush;
  assign hz.state_dbg_o  = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf_stall (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (stall),
    .cnt_o   (hz.perf_stall_o)
  );

  hazard_perf_cnt u_perf_flush (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (flush),
    .cnt_o   (hz.perf_flush_o)
  );
`else
  assign hz.perf_stall_o = '0;
  assign hz.perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table on LOAD_STALL=1 plus multi-cycle sequences
// on LOAD_STALL=3 and LOAD_STALL=4 instances sharing the same ID/EX stimulus.
module tb_hazard_ctrl;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs1, rs2, rrd;
  logic       u1, u2, mr, br;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_if #(.REG_ADDR_W(5)) if_1 ();
  hazard_ctrl_if #(.REG_ADDR_W(5)) if_3 ();
  hazard_ctrl_if #(.REG_ADDR_W(5)) if_4 ();

  assign if_1.rs1_i = rs1;  assign if_1.rs2_i = rs2;  assign if_1.rrd_i = rrd;
  assign if_1.rs1_use_i = u1;  assign if_1.rs2_use_i = u2;
  assign if_1.mem_rd_i = mr;  assign if_1.branch_taken_i = br;
  assign if_3.rs1_i = rs1;  assign if_3.rs2_i = rs2;  assign if_3.rrd_i = rrd;
  assign if_3.rs1_use_i = u1;  assign if_3.rs2_use_i = u2;
  assign if_3.mem_rd_i = mr;  assign if_3.branch_taken_i = br;
  assign if_4.rs1_i = rs1;  assign if_4.rs2_i = rs2;  assign if_4.rrd_i = rrd;
  assign if_4.rs1_use_i = u1;  assign if_4.rs2_use_i = u2;
  assign if_4.mem_rd_i = mr;  assign if_4.branch_taken_i = br;

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1)) u_dut1 (.clk_i(clk), .rst_n_i(rst_n), .hz(if_1.slave));
  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3)) u_dut3 (.clk_i(clk), .rst_n_i(rst_n), .hz(if_3.slave));
  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(4)) u_dut4 (.clk_i(clk), .rst_n_i(rst_n), .hz(if_4.slave));

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rrd;
    logic       mr, br;
    logic       e_stall, e_flush;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic ua,
                              input logic ub, input logic [4:0] d, input logic m,
                              input logic t, input logic es, input logic ef);
    vec_t v;
    v.rs1 = a; v.rs2 = b; v.u1 = ua; v.u2 = ub; v.rrd = d;
    v.mr = m; v.br = t; v.e_stall = es; v.e_flush = ef;
    return v;
  endfunction

  task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic ua,
                        input logic ub, input logic [4:0] d, input logic m, input logic t);
    rs1 = a; rs2 = b; u1 = ua; u2 = ub; rrd = d; mr = m; br = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic mux, input logic ifw, input logic pcw,
                         input logic fl, input logic e_stall, input logic e_flush);
    chk({name, ".mux"},   {31'd0, mux}, {31'd0, e_stall});
    chk({name, ".ifidw"}, {31'd0, ifw}, {31'd0, !e_stall});
    chk({name, ".pcw"},   {31'd0, pcw}, {31'd0, !e_stall});
    chk({name, ".flush"}, {31'd0, fl},  {31'd0, e_flush});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(5'd1,  5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(5'd9,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(5'd9,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(5'd3,  5'd4,  1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1);
    vecs[8]  = mk(5'd5,  5'd4,  1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(5'd30, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(5'd30, 5'd29, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset state: a hit plus taken branch must be masked while reset is held.
    rst_n = 1'b0;
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk_ctl("rst", if_3.mux_o, if_3.IFID_write_o, if_3.pc_write_o, if_3.IFID_flush_o, 1'b0, 1'b0);
    chk("rst.state", {31'd0, if_3.state_dbg_o}, {31'd0, IDLE});
    chk("rst.perf_stall", if_3.perf_stall_o, 32'd0);
    chk("rst.perf_flush", if_3.perf_flush_o, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Single-cycle stall table on LOAD_STALL=1.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rrd, vecs[i].mr, vecs[i].br);
      @(negedge clk);
      chk_ctl($sformatf("vec%0d", i), if_1.mux_o, if_1.IFID_write_o, if_1.pc_write_o,
              if_1.IFID_flush_o, vecs[i].e_stall, vecs[i].e_flush);
      chk($sformatf("vec%0d.state", i), {31'd0, if_1.state_dbg_o}, {31'd0, IDLE});
      next_cycle();
    end

    // LOAD_STALL=3: hit, then EX bubbles; branch during stall flushes only once released.
    do_reset();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk_ctl("ls3.c0", if_3.mux_o, if_3.IFID_write_o, if_3.pc_write_o, if_3.IFID_flush_o, 1'b1, 1'b0);
    next_cycle();
    mr = 1'b0;
    @(negedge clk);
    chk_ctl("ls3.c1", if_3.mux_o, if_3.IFID_write_o, if_3.pc_write_o, if_3.IFID_flush_o, 1'b1, 1'b0);
    chk("ls3.c1.state", {31'd0, if_3.state_dbg_o}, {31'd0, HOLD});
    next_cycle();
    br = 1'b1;
    @(negedge clk);
    chk_ctl("ls3.c2", if_3.mux_o, if_3.IFID_write_o, if_3.pc_write_o, if_3.IFID_flush_o, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_ctl("ls3.c3", if_3.mux_o, if_3.IFID_write_o, if_3.pc_write_o, if_3.IFID_flush_o, 1'b0, 1'b1);
    chk("ls3.c3.state", {31'd0, if_3.state_dbg_o}, {31'd0, IDLE});
    next_cycle();
    br = 1'b0;
    @(negedge clk);
    chk_ctl("ls3.c4", if_3.mux_o, if_3.IFID_write_o, if_3.pc_write_o, if_3.IFID_flush_o, 1'b0, 1'b0);
    chk("ls3.perf_stall", if_3.perf_stall_o, 32'(3 * PERF));
    chk("ls3.perf_flush", if_3.perf_flush_o, 32'(1 * PERF));
    next_cycle();

    // LOAD_STALL=4: reset asserted during the second HOLD cycle.
    do_reset();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk_ctl("ls4.c0", if_4.mux_o, if_4.IFID_write_o, if_4.pc_write_o, if_4.IFID_flush_o, 1'b1, 1'b0);
    next_cycle();
    mr = 1'b0;
    @(negedge clk);
    chk_ctl("ls4.c1", if_4.mux_o, if_4.IFID_write_o, if_4.pc_write_o, if_4.IFID_flush_o, 1'b1, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    mr = 1'b1;
    br = 1'b1;
    @(negedge clk);
    chk("ls4.c2.state", {31'd0, if_4.state_dbg_o}, {31'd0, HOLD});
    chk_ctl("ls4.c2rst", if_4.mux_o, if_4.IFID_write_o, if_4.pc_write_o, if_4.IFID_flush_o, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    mr = 1'b0;
    br = 1'b0;
    @(negedge clk);
    chk_ctl("ls4.c3", if_4.mux_o, if_4.IFID_write_o, if_4.pc_write_o, if_4.IFID_flush_o, 1'b0, 1'b0);
    chk("ls4.c3.state", {31'd0, if_4.state_dbg_o}, {31'd0, IDLE});
    chk("ls4.perf_stall", if_4.perf_stall_o, 32'd0);
    next_cycle();

    // Ten back-to-back hazards on LOAD_STALL=1.
    do_reset();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("burst%0d.mux", i), {31'd0, if_1.mux_o}, 32'd1);
      next_cycle();
    end
    mr = 1'b0;
    @(negedge clk);
    chk("burst.mux", {31'd0, if_1.mux_o}, 32'd0);
    chk("burst.perf_stall", if_1.perf_stall_o, 32'(10 * PERF));
    chk("burst.perf_flush", if_1.perf_flush_o, 32'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised load-use hazard and control-flow controller for the 5-stage pipelined CPU; replaces the single-cycle load-use detector between the ID and EX stages. Compares ID-stage source registers against the load in EX and stalls PC/IF-ID while bubbling ID/EX. A counter FSM extends the stall for multi-cycle data memories. Also flushes IF/ID on a taken branch and masks unused source operands to avoid false stalls.

## Interface

- REG_ADDR_W, 5, register-index width
- LOAD_STALL, 1, stall cycles per load-use hazard (data-memory latency); legal range 1..15
- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low
- rs1_i  in  REG_ADDR_W  rs1 index of instruction in ID
- rs2_i  in  REG_ADDR_W  rs2 index of instruction in ID
- rs1_use_i  in  1  ID instruction reads rs1
- rs2_use_i  in  1  ID instruction reads rs2
- rrd_i  in  REG_ADDR_W  rd of instruction in EX
- mem_rd_i  in  1  EX instruction is a load
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- mux_o  out  1  1 = insert bubble into ID/EX
- IFID_write_o  out  1  0 = hold IF/ID register
- pc_write_o  out  1  0 = hold PC
- IFID_flush_o  out  1  1 = clear IF/ID to NOP
- perf_stall_o  out  32  stall-cycle count (see Configuration)
- perf_flush_o  out  32  flush count (see Configuration)

## Operation

- Detect (combinational): hit = mem_rd_i && rrd_i != 0 && ((rs1_use_i && rs1_i == rrd_i) || (rs2_use_i && rs2_i == rrd_i)).
- stall = (state == IDLE && hit) || state == HOLD.
- mux_o = stall; IFID_write_o = !stall; pc_write_o = !stall.
- IFID_flush_o = branch_taken_i && !stall (a stalled branch reads stale operands; its flush waits until it resolves unstalled).
- FSM states: IDLE, HOLD; down-counter cnt, width clog2(LOAD_STALL+1).
- IDLE: hit && LOAD_STALL > 1 -> HOLD, cnt = LOAD_STALL-1; otherwise stay.
- HOLD: EX inputs ignored (EX holds a bubble); cnt decrements; cnt == 1 -> IDLE.
- Total stall per hazard = exactly LOAD_STALL consecutive cycles; with LOAD_STALL = 1 the FSM never leaves IDLE.
- rd = x0 never causes a hazard; rs1 == rs2 == rrd counts once.

## Timing

- Detection to outputs: 0 cycles (same-cycle combinational); FSM updates on clk_i rising edge.
- Cycle after HOLD exit: IDLE, detection re-evaluated normally.
- Reset (rst_n_i low at edge): state IDLE, cnt 0, perf counters 0. While rst_n_i is low, outputs forced mux_o=0, IFID_write_o=1, pc_write_o=1, IFID_flush_o=0.
- Reset mid-HOLD: stall drops the cycle reset is sampled; no residual stall after release.
- hit and branch_taken_i together: stall wins, IFID_flush_o = 0.

## Configuration

- HAZARD_PERF_EN defined: perf_stall_o increments on every cycle stall = 1; perf_flush_o increments on every cycle IFID_flush_o = 1; both saturate at 0xFFFFFFFF and clear on reset.
- HAZARD_PERF_EN undefined: no counter flops; perf_stall_o and perf_flush_o tied to 0; ports remain so instantiation is unchanged.

## Structure

- hazard_pkg: state typedef (IDLE, HOLD), REG_ADDR_ZERO constant, default REG_ADDR_W.
- Sub-module hazard_perf_cnt: 32-bit saturating counter with enable and synchronous active-low clear; two instances, present only under HAZARD_PERF_EN.

## Test plan

- LOAD_STALL=1, mem_rd_i=1, rrd_i=5, rs1_i=5, rs1_use_i=1 -> mux_o=1, IFID_write_o=0, pc_write_o=0 for exactly 1 cycle.
- LOAD_STALL=3, same hit then EX bubble (mem_rd_i=0) -> stall held 3 consecutive cycles, then released; perf_stall_o = 3 with HAZARD_PERF_EN.
- rrd_i=0 with rs1_i=0; or rs2_i=7=rrd_i with rs2_use_i=0 -> no stall.
- branch_taken_i=1 with hit -> IFID_flush_o=0 while stalled; branch_taken_i=1 with no hit -> IFID_flush_o=1 and perf_flush_o +1.
- LOAD_STALL=4, rst_n_i low during 2nd HOLD cycle -> outputs non-stall that cycle; after release IDLE with no stall.
- Without HAZARD_PERF_EN, 10 hazards -> perf_stall_o = perf_flush_o = 0.
